mult_seq_driver: RTL and testbench
==================================

Name: mult_seq_driver

Overview:
- On-board initiator for the 8-bit add/shift multiplier `Processor`. Performs in hardware the same operation sequence a bench applies to it:
  - load B through Reset_Load_Clear;
  - present the multiplicand S on SW;
  - pulse Run;
  - read back {Aval,Bval} and Xval.
- Compares the DUT result against an internally computed signed 8x8 product and reports Pass/Fail.
- Sits between top-level switches/buttons and the Processor instance, so the multiplier can self-test on the FPGA.

Parameters:
- LOAD_CYCLES, 4: cycles Reset_Load_Clear is held high; also the idle gap before Run.
- RUN_CYCLES, 24: cycles Run is held high. Must cover the DUT input synchronizer plus 8 add/shift steps.
- SETTLE_CYCLES, 4: cycles after Run falls before DUT outputs are sampled.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request one multiply/check; sampled only in IDLE
- Op_A  in  8  multiplicand S (signed); captured at Start
- Op_B  in  8  multiplier B (signed); captured at Start
- Reset_Load_Clear  out  1  to DUT: load SW into B, clear A/X
- Run  out  1  to DUT: start multiply
- SW  out  8  to DUT switch bus
- Aval  in  8  from DUT: upper product byte
- Bval  in  8  from DUT: lower product byte
- Xval  in  1  from DUT: sign extension bit
- Busy  out  1  high from LOAD through CHECK
- Done  out  1  one-cycle pulse; Product, Expected and Pass are valid from this cycle until the next Start
- Product  out  16  registered {Aval,Bval} sampled in CHECK
- Expected  out  16  signed(Op_A) * signed(Op_B), 16-bit two's complement
- Pass  out  1  1 when Product==Expected and Xval==Expected[15]
- Err_Count  out  8  failed-check counter (see Optional Feature)

Behaviour:
- Clock/reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; captured operands 0; internal counter 0.
- States: IDLE, LOAD, GAP, RUN, SETTLE, CHECK, DONE.
- IDLE:
  - Outputs Reset_Load_Clear=0, Run=0, SW=0, Busy=0.
  - Start=1 captures Op_A/Op_B into internal registers and goes to LOAD.
- LOAD: SW=captured B, Reset_Load_Clear=1, Busy=1. Lasts LOAD_CYCLES, then goes to GAP.
- GAP: Reset_Load_Clear=0. SW stays at B for the first cycle, then is captured A. Lasts LOAD_CYCLES, then goes to RUN.
- RUN: SW=captured A, Run=1. Lasts RUN_CYCLES, then goes to SETTLE.
- SETTLE: Run=0, SW=A held. Lasts SETTLE_CYCLES, then goes to CHECK.
- CHECK (1 cycle):
  - Register Product={Aval,Bval}.
  - Compute Pass.
  - Go to DONE.
- DONE (1 cycle): Done=1, Busy=0, then return to IDLE.
- Latency: with Start seen at cycle 0, Done is asserted at cycle 2*LOAD_CYCLES+RUN_CYCLES+SETTLE_CYCLES+2 (38 with defaults).
- Reset_Load_Clear and Run are never high in the same cycle. Each is exactly one contiguous pulse per operation.
- Expected:
  - Computed from the captured operands as signed 8x8 to 16-bit. No overflow is possible.
  - Registered at Start capture. Stable through DONE and afterwards.
- Start while Busy is ignored: no recapture, no restart. Start held high in IDLE launches back-to-back operations, one per visit to IDLE.
- Reset in any state, including mid-RUN: next cycle is IDLE with all outputs 0. A partially run DUT operation is abandoned and Done is not pulsed.
- Op_A/Op_B changing after capture has no effect on the current operation.
- Aval/Bval/Xval are sampled only in CHECK. Values in other cycles are don't-care.

Optional Feature:
- Macro: MULT_SEQ_ERRCNT_EN.
- Defined:
  - Err_Count increments by 1 in CHECK whenever Pass=0, saturating at 8'hFF.
  - Cleared only by Reset.
  - Err_Count is not cleared by Start.
- Undefined: the counter logic is omitted and Err_Count is tied to 8'h00. Port list is unchanged.

Test Plan:
- Basic signed case:
  - Stimulus: Op_B=8'hFF (-1), Op_A=8'hFE (-2), Start pulse, correct DUT.
  - Required: Reset_Load_Clear high cycles 1-4; Run high cycles 9-32; Done at cycle 38 with Product=16'h0002, Expected=16'h0002, Xval=0, Pass=1.
- Negative extreme:
  - Stimulus: Op_A=8'h80, Op_B=8'h80.
  - Required: Expected=16'h4000, Pass=1.
- Mixed signs:
  - Stimulus: Op_A=8'h7F, Op_B=8'h81.
  - Required: Expected=16'hC0FF, Xval=1, Pass=1.
- Reset and Start-while-busy:
  - Stimulus: Reset asserted at cycle 15 (in RUN).
  - Required: next cycle Run=0, Busy=0, state IDLE, no Done. A subsequent Start restarts cleanly with correct timing.
  - Stimulus: Start pulsed at cycle 10 during an operation.
  - Required: ignored; exactly one Done at cycle 38.
- Faulty DUT (bench model with Bval stuck at 8'h00):
  - Stimulus: Op_A=8'h03, Op_B=8'h05.
  - Required: Product=16'h0000, Expected=16'h000F, Pass=0.
  - With MULT_SEQ_ERRCNT_EN: Err_Count=1, and Err_Count=2 after a second failing run.
  - Without it: Err_Count=0.

Source files
------------

// File: rtl/mult_seq_driver.sv
// Hardware initiator and checker for the 8-bit add/shift multiplier (Processor).
// Optional failed-check counter enabled by defining MULT_SEQ_ERRCNT_EN.
//
// state  | meaning
// IDLE   | waiting for Start, all strobes low
// LOAD   | Reset_Load_Clear high, SW = B
// GAP    | strobes low, SW = B for one cycle then A
// RUN    | Run high, SW = A
// SETTLE | Run low, SW = A, waiting for DUT outputs
// CHECK  | sample {Aval,Bval}/Xval, compute Pass
// DONE   | one-cycle Done pulse
module mult_seq_driver #(
  parameter int LOAD_CYCLES   = 4,
  parameter int RUN_CYCLES    = 24,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Op_A,
  input  logic [7:0]  Op_B,
  output logic        Reset_Load_Clear,
  output logic        Run,
  output logic [7:0]  SW,
  input  logic [7:0]  Aval,
  input  logic [7:0]  Bval,
  input  logic        Xval,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Product,
  output logic [15:0] Expected,
  output logic        Pass,
  output logic [7:0]  Err_Count
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, RUN, SETTLE, CHECK, DONE} state_t;

  localparam int CW = 8;
  localparam logic [CW-1:0] LOAD_TC   = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] RUN_TC    = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    op_a_q;
  logic [7:0]    op_b_q;
  logic [15:0]   prod_next;
  logic          pass_next;

  // Sign-extending both operands to 16 bits makes the low half of the
  // unsigned product equal to the signed two's-complement product.
  assign prod_next = {{8{Op_A[7]}}, Op_A} * {{8{Op_B[7]}}, Op_B};
  assign pass_next = ({Aval, Bval} == Expected) && (Xval == Expected[15]);

`ifdef MULT_SEQ_ERRCNT_EN
  logic [7:0] err_q;
  assign Err_Count = err_q;
`else
  assign Err_Count = 8'h00;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= IDLE;
      cnt              <= '0;
      op_a_q           <= 8'h00;
      op_b_q           <= 8'h00;
      Reset_Load_Clear <= 1'b0;
      Run              <= 1'b0;
      SW               <= 8'h00;
      Busy             <= 1'b0;
      Done             <= 1'b0;
      Product          <= 16'h0000;
      Expected         <= 16'h0000;
      Pass             <= 1'b0;
`ifdef MULT_SEQ_ERRCNT_EN
      err_q            <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_a_q           <= Op_A;
            op_b_q           <= Op_B;
            Expected         <= prod_next;
            SW               <= Op_B;
            Reset_Load_Clear <= 1'b1;
            Busy             <= 1'b1;
            cnt              <= LOAD_TC;
            state            <= LOAD;
          end
        end
        LOAD: begin
          if (cnt == '0) begin
            Reset_Load_Clear <= 1'b0;
            cnt              <= LOAD_TC;
            state            <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          // B stays on the bus for the first GAP cycle so the load edge is clean.
          SW <= op_a_q;
          if (cnt == '0) begin
            Run   <= 1'b1;
            cnt   <= RUN_TC;
            state <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            Run   <= 1'b0;
            cnt   <= SETTLE_TC;
            state <= SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          Product <= {Aval, Bval};
          Pass    <= pass_next;
`ifdef MULT_SEQ_ERRCNT_EN
          if (!pass_next && (err_q != 8'hFF)) err_q <= err_q + 8'h01;
`endif
          SW      <= 8'h00;
          Busy    <= 1'b0;
          Done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_driver.sv
// Scoreboard bench for mult_seq_driver with a behavioural Processor model
// (optional Bval-stuck-at-zero fault); honours MULT_SEQ_ERRCNT_EN.
module tb_mult_seq_driver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Op_A = 8'h00;
  logic [7:0]  Op_B = 8'h00;
  logic        Reset_Load_Clear, Run, Busy, Done, Pass;
  logic [7:0]  SW, Aval, Bval, Err_Count;
  logic        Xval;
  logic [15:0] Product, Expected;

  mult_seq_driver dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op_A(Op_A), .Op_B(Op_B),
    .Reset_Load_Clear(Reset_Load_Clear), .Run(Run), .SW(SW),
    .Aval(Aval), .Bval(Bval), .Xval(Xval), .Busy(Busy), .Done(Done),
    .Product(Product), .Expected(Expected), .Pass(Pass), .Err_Count(Err_Count)
  );

  always #5 Clk = ~Clk;

  int edge_n = 0;
  always @(posedge Clk) edge_n++;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic logic [15:0] smul(logic [7:0] a, logic [7:0] b);
    int ia, ib, p;
    ia = a; if (ia > 127) ia -= 256;
    ib = b; if (ib > 127) ib -= 256;
    p = ia * ib;
    return p[15:0];
  endfunction

  // Behavioural multiplier: loads B on Reset_Load_Clear, takes S at the first
  // Run cycle, presents the signed product after 12 Run cycles.
  bit         fault = 1'b0;
  logic [7:0] m_b = 8'h00, m_s = 8'h00, m_a = 8'h00, m_bl = 8'h00;
  logic       m_x = 1'b0;
  int         m_run = 0;
  always @(posedge Clk) begin
    if (Reset_Load_Clear) begin
      m_b <= SW; m_bl <= SW; m_a <= 8'h00; m_x <= 1'b0; m_run <= 0;
    end else if (Run) begin
      m_run <= m_run + 1;
      if (m_run == 0) m_s <= SW;
      if (m_run == 12) begin
        {m_a, m_bl} <= smul(m_s, m_b);
        m_x         <= smul(m_s, m_b) >> 15;
      end
    end else begin
      m_run <= 0;
    end
  end
  assign Aval = m_a;
  assign Bval = fault ? 8'h00 : m_bl;
  assign Xval = m_x;

  typedef struct {
    int          s;
    logic [7:0]  a, b;
    logic [15:0] prod, expv;
    logic        pass;
    logic [7:0]  err;
  } item_t;
  item_t sb[$];
  int    errs = 0;

  task automatic push_op(input logic [7:0] a, input logic [7:0] b, input bit f, input int s);
    item_t it;
    it.s    = s;
    it.a    = a;
    it.b    = b;
    it.expv = smul(a, b);
    it.prod = f ? {it.expv[15:8], 8'h00} : it.expv;
    it.pass = (it.prod == it.expv);
    if (!it.pass && errs < 255) errs++;
`ifdef MULT_SEQ_ERRCNT_EN
    it.err = 8'(errs);
`else
    it.err = 8'h00;
`endif
    sb.push_back(it);
  endtask

  // Monitor: cycle-level strobe/bus timing against the oldest pending op, and
  // result comparison whenever Done is presented.
  bit mon_en = 1'b0;
  always @(negedge Clk) if (mon_en) begin
    logic [3:0] exp_ctl;
    logic [7:0] exp_sw;
    bit         sw_care;
    int         rel;
    item_t      it;
    exp_ctl = 4'b0000; exp_sw = 8'h00; sw_care = 1'b1;
    if (sb.size() > 0) begin
      rel = edge_n - sb[0].s + 1;
      exp_ctl = {rel >= 1 && rel <= 4, rel >= 9 && rel <= 32, rel >= 1 && rel <= 37, rel == 38};
      if (rel >= 1 && rel <= 5)       exp_sw = sb[0].b;
      else if (rel >= 6 && rel <= 37) exp_sw = sb[0].a;
      sw_care = (rel != 38);
    end
    chk("ctl{rlc,run,busy,done}", {Reset_Load_Clear, Run, Busy, Done}, exp_ctl);
    if (sw_care) chk("sw", SW, exp_sw);
    if (Reset_Load_Clear && Run) chk("rlc_run_overlap", 1, 0);
    if (Done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        it = sb.pop_front();
        chk("product", Product, it.prod);
        chk("expected", Expected, it.expv);
        chk("pass", Pass, it.pass);
        chk("err_count", Err_Count, it.err);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit f, output int s);
    @(negedge Clk); #1;
    Op_A = a; Op_B = b; fault = f; Start = 1'b1;
    s = edge_n + 1;
    push_op(a, b, f, s);
    @(negedge Clk); #1;
    Start = 1'b0;
    Op_A = 8'($urandom); Op_B = 8'($urandom);
  endtask

  task automatic wait_to(input int target);
    while (edge_n < target) @(negedge Clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge Clk);
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit f);
    int s;
    issue(a, b, f, s);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge Clk);
    chk("reset_ctl", {Reset_Load_Clear, Run, Busy, Done}, 0);
    chk("reset_sw", SW, 0);
    chk("reset_product", Product, 0);
    chk("reset_expected", Expected, 0);
    chk("reset_pass", Pass, 0);
    chk("reset_err", Err_Count, 0);
    #1 Reset = 1'b0;
    mon_en = 1'b1;

    run_op(8'hFE, 8'hFF, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h7F, 8'h81, 1'b0);
    run_op(8'h03, 8'h05, 1'b1);
    run_op(8'h03, 8'h05, 1'b1);

    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), ($urandom_range(3) == 0));

    // Reset mid-RUN abandons the op; next Start must run cleanly.
    issue(8'h11, 8'h22, 1'b0, s);
    wait_to(s + 14);
    Reset = 1'b1;
    sb.delete();
    errs = 0;
    @(negedge Clk); #1;
    Reset = 1'b0;
    run_op(8'hC3, 8'h5A, 1'b0);

    // Start pulse while busy is ignored.
    issue(8'h12, 8'hF3, 1'b0, s);
    wait_to(s + 9);
    Start = 1'b1; Op_A = 8'h55; Op_B = 8'h66;
    @(negedge Clk); #1;
    Start = 1'b0;
    wait_idle();
    repeat (5) @(negedge Clk);

    // Start held high: back-to-back ops; operands changed mid-op go to the next one.
    @(negedge Clk); #1;
    Op_A = 8'h9C; Op_B = 8'h37; fault = 1'b0; Start = 1'b1;
    s = edge_n + 1;
    push_op(8'h9C, 8'h37, 1'b0, s);
    wait_to(s + 9);
    Op_A = 8'h6B; Op_B = 8'hE2;
    push_op(8'h6B, 8'hE2, 1'b0, s + 39);
    wait_to(s + 39);
    Start = 1'b0;
    wait_idle();

    // Long run of failing checks exercises counter saturation.
    for (int i = 0; i < 258; i++) run_op(8'h03, 8'h05, 1'b1);
    run_op(8'hFE, 8'hFF, 1'b0);

    repeat (5) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
